// File: rtl/shift_deserializer_pkg.sv
// Shared definitions for the SoC/JTAG serial link receive side.
// The word length is shared with the transmit-side shift register so both
// ends of the link agree on the frame size.
package shift_deserializer_pkg;

    // Default serial frame length in bits (LSB transmitted first).
    localparam int unsigned DESER_LENGTH = 32;

    // One-entry holding buffer occupancy.
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/deser_holding_buf.sv
// One-entry valid/ready holding buffer for completed deserializer words.
// A word completing while the buffer is full and not being drained is
// dropped and recorded in a sticky overrun flag.
module deser_holding_buf
    import shift_deserializer_pkg::*;
#(
    parameter int unsigned LENGTH = DESER_LENGTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              complete_i,
    input  logic [LENGTH-1:0] word_i,
    input  logic              ready_i,
    input  logic              clr_ovr_i,
    output logic [LENGTH-1:0] data_o,
    output logic              valid_o,
    output logic              overrun_o
);

    buf_state_e        state_q, state_d;
    logic [LENGTH-1:0] data_q, data_d;
    logic              ovr_q, ovr_d;

    // Next-state logic: load on completion, drain on handshake, flag drops.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ovr_d   = ovr_q;

        // Clear first so that a same-cycle drop below overrides it.
        if (clr_ovr_i) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end

        case (state_q)
            BUF_EMPTY: begin
                if (complete_i) begin
                    data_d  = word_i;
                    state_d = BUF_FULL;
                end else begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (ready_i) begin
                    if (complete_i) begin
                        // Old word leaves, new word enters: no bubble.
                        data_d  = word_i;
                        state_d = BUF_FULL;
                    end else begin
                        // Data left as-is; it is don't-care while empty.
                        state_d = BUF_EMPTY;
                    end
                end else begin
                    if (complete_i) begin
                        // Keep the unconsumed word, drop the new one.
                        ovr_d = 1'b1;
                    end else begin
                        ovr_d = ovr_d;
                    end
                    state_d = BUF_FULL;
                end
            end
            default: begin
                state_d = BUF_EMPTY;
            end
        endcase
    end

    // Buffer state, data and overrun registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
            data_q  <= {LENGTH{1'b0}};
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = (state_q == BUF_FULL);
    assign overrun_o = ovr_q;

endmodule

// File: rtl/shift_deserializer.sv
// Serial-in, parallel-out capture register for the SoC/JTAG link.
// Bits arrive LSB first; each completed LENGTH-bit word is handed to the
// SoC through a one-entry valid/ready holding buffer.
module shift_deserializer
    import shift_deserializer_pkg::*;
#(
    parameter  int unsigned LENGTH = DESER_LENGTH,
    localparam int unsigned CNT_W  = $clog2(LENGTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jtagInput,
    input  logic              shiftIn,
    input  logic              frameClear,
    input  logic              socReady,
    input  logic              clrOverrun,
    output logic [LENGTH-1:0] socData,
    output logic              socValid,
    output logic [CNT_W-1:0]  bitCount,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(LENGTH - 1);

    logic [LENGTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [LENGTH-1:0] word_s;
    logic              complete_s;

    // New bits enter at the MSB so the first bit ends up in bit 0.
    assign word_s = {jtagInput, shift_q[LENGTH-1:1]};

    // Capture, count and frame-completion detection; abort has priority.
    always_comb begin
        shift_d    = shift_q;
        count_d    = count_q;
        complete_s = 1'b0;
        if (frameClear) begin
            shift_d = {LENGTH{1'b0}};
            count_d = {CNT_W{1'b0}};
        end else if (shiftIn) begin
            shift_d = word_s;
            if (count_q == LAST_BIT) begin
                count_d    = {CNT_W{1'b0}};
                complete_s = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1'b1);
            end
        end else begin
            shift_d = shift_q;
            count_d = count_q;
        end
    end

    // Shift register and bit counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= {LENGTH{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    assign bitCount = count_q;

    deser_holding_buf #(
        .LENGTH (LENGTH)
    ) u_holding_buf (
        .clk        (clk),
        .rst_n      (rst),
        .complete_i (complete_s),
        .word_i     (word_s),
        .ready_i    (socReady),
        .clr_ovr_i  (clrOverrun),
        .data_o     (socData),
        .valid_o    (socValid),
        .overrun_o  (overrun)
    );

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer: directed scenarios followed by
// randomized traffic, all checked against a word-level reference model.
module tb_shift_deserializer;

    logic        clk;
    logic        rst;
    logic        jtagInput;
    logic        shiftIn;
    logic        frameClear;
    logic        socReady;
    logic        clrOverrun;
    logic [31:0] socData;
    logic        socValid;
    logic [4:0]  bitCount;
    logic        overrun;

    shift_deserializer dut (
        .clk        (clk),
        .rst        (rst),
        .jtagInput  (jtagInput),
        .shiftIn    (shiftIn),
        .frameClear (frameClear),
        .socReady   (socReady),
        .clrOverrun (clrOverrun),
        .socData    (socData),
        .socValid   (socValid),
        .bitCount   (bitCount),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: bits placed by index into a word, plus buffer flags.
    logic [31:0] m_word;
    int          m_cnt;
    bit          m_valid;
    logic [31:0] m_data;
    bit          m_ovr;

    int          cyc;
    int          valid_seen;
    int          valid_cyc[$];
    logic [31:0] valid_dat[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_word  = 32'h0;
        m_cnt   = 0;
        m_valid = 0;
        m_data  = 32'h0;
        m_ovr   = 0;
    endtask

    task automatic model_step(input bit fc, input bit si, input bit b, input bit rdy, input bit clr);
        bit          done;
        logic [31:0] w;
        done = 0;
        w    = 32'h0;
        if (fc) begin
            m_word = 32'h0;
            m_cnt  = 0;
        end else if (si) begin
            m_word[m_cnt] = b;
            if (m_cnt == 31) begin
                done  = 1;
                w     = m_word;
                m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        if (clr) m_ovr = 0;
        if (done) begin
            if (!m_valid || rdy) begin
                m_data  = w;
                m_valid = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_outputs();
        check("socValid", {31'b0, socValid}, {31'b0, m_valid});
        check("bitCount", {27'b0, bitCount}, m_cnt);
        check("overrun", {31'b0, overrun}, {31'b0, m_ovr});
        if (m_valid) check("socData", socData, m_data);
    endtask

    // One clock cycle: drive inputs, clock, then sample and compare.
    task automatic step(input bit fc, input bit si, input bit b, input bit rdy, input bit clr);
        frameClear = fc;
        shiftIn    = si;
        jtagInput  = b;
        socReady   = rdy;
        clrOverrun = clr;
        @(posedge clk);
        #1;
        cyc++;
        model_step(fc, si, b, rdy, clr);
        compare_outputs();
        if (socValid) begin
            valid_seen++;
            valid_cyc.push_back(cyc);
            valid_dat.push_back(socData);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit rdy, input bit gapped);
        for (int i = 0; i < 32; i++) begin
            step(0, 1, w[i], rdy, 0);
            if (gapped && i < 31) step(0, 0, 0, rdy, 0);
        end
    endtask

    task automatic drain();
        step(0, 0, 0, 1, 0);
    endtask

    initial begin
        cyc = 0;
        valid_seen = 0;
        rst = 1'b0;
        jtagInput = 1'b0; shiftIn = 1'b0; frameClear = 1'b0;
        socReady = 1'b0; clrOverrun = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'b0, socValid}, 32'h0);
        check("rst_count", {27'b0, bitCount}, 32'h0);
        check("rst_data", socData, 32'h0);
        check("rst_ovr", {31'b0, overrun}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Basic word, no ready.
        send_word(32'hDEADBEEF, 0, 0);
        check("basic_valid", {31'b0, socValid}, 32'h1);
        check("basic_data", socData, 32'hDEADBEEF);
        check("basic_count", {27'b0, bitCount}, 32'h0);
        check("basic_ovr", {31'b0, overrun}, 32'h0);
        drain();

        // Gapped bits, bitCount midway.
        for (int i = 0; i < 32; i++) begin
            step(0, 1, (i == 0), 0, 0);
            if (i == 15) check("gap_mid_count", {27'b0, bitCount}, 32'd16);
            if (i < 31) step(0, 0, 0, 0, 0);
        end
        check("gap_data", socData, 32'h00000001);
        check("gap_valid", {31'b0, socValid}, 32'h1);
        drain();

        // Back-to-back with ready held high.
        valid_seen = 0;
        valid_cyc.delete();
        valid_dat.delete();
        send_word(32'h12345678, 1, 0);
        send_word(32'hA5A5A5A5, 1, 0);
        step(0, 0, 0, 1, 0);
        check("b2b_count", valid_seen, 32'd2);
        if (valid_seen == 2) begin
            check("b2b_word0", valid_dat[0], 32'h12345678);
            check("b2b_word1", valid_dat[1], 32'hA5A5A5A5);
            check("b2b_spacing", valid_cyc[1] - valid_cyc[0], 32'd32);
        end
        check("b2b_ovr", {31'b0, overrun}, 32'h0);

        // Overrun.
        send_word(32'h11111111, 0, 0);
        send_word(32'h22222222, 0, 0);
        check("ovr_data", socData, 32'h11111111);
        check("ovr_flag", {31'b0, overrun}, 32'h1);
        step(0, 0, 0, 0, 1);
        check("ovr_clear", {31'b0, overrun}, 32'h0);
        drain();

        // Abort mid-frame.
        for (int i = 0; i < 10; i++) step(0, 1, 1'($urandom), 0, 0);
        step(1, 1, 1, 0, 0);
        check("abort_count", {27'b0, bitCount}, 32'h0);
        send_word(32'hCAFEF00D, 0, 0);
        check("abort_data", socData, 32'hCAFEF00D);
        drain();

        // Async reset mid-frame while a word is held.
        send_word(32'h0F0F1234, 0, 0);
        for (int i = 0; i < 17; i++) step(0, 1, 1'($urandom), 0, 0);
        check("pre_rst_count", {27'b0, bitCount}, 32'd17);
        check("pre_rst_valid", {31'b0, socValid}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", {31'b0, socValid}, 32'h0);
        check("arst_count", {27'b0, bitCount}, 32'h0);
        check("arst_data", socData, 32'h0);
        check("arst_ovr", {31'b0, overrun}, 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        send_word(32'h5A5AC3C3, 0, 0);
        check("post_rst_data", socData, 32'h5A5AC3C3);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom),
                 1'($urandom),
                 ($urandom_range(0, 15) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
